// File: rtl/fetch_stage.sv
// Instruction fetch: drives imem, registers one instruction per cycle into IF/ID (1-cycle latency after imem_ready).
// Backpressure: a response that IF/ID cannot take parks in a one-entry skid; a redirect over a waited access drains it first.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipeline_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_instruction,
  output logic        if_valid
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD, DRAIN} state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] drain_pc;
  logic [31:0] skid_pc;
  logic [31:0] skid_instr;
  logic [31:0] redirect_tgt;
  logic        accept;

  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
  assign accept       = !if_valid || pipeline_en;

  // Decoded straight from the state register, so the memory sees no input-to-output path.
  assign imem_req  = (state == FETCH) || (state == DRAIN);
  assign imem_addr = (state == DRAIN) ? drain_pc : fetch_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= BOOT;
      fetch_pc       <= RESET_PC & 32'hFFFF_FFFC;
      drain_pc       <= 32'h0;
      skid_pc        <= 32'h0;
      skid_instr     <= NOP_INSTR;
      if_pc          <= 32'h0;
      if_instruction <= NOP_INSTR;
      if_valid       <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state <= FETCH;
          if (redirect_valid) begin
            fetch_pc       <= redirect_tgt;
            if_valid       <= 1'b0;
            if_instruction <= NOP_INSTR;
          end
        end

        FETCH: begin
          if (redirect_valid) begin
            if_valid       <= 1'b0;
            if_instruction <= NOP_INSTR;
            fetch_pc       <= redirect_tgt;
            // The outstanding access must complete at its original address before refetching.
            if (!imem_ready) begin
              drain_pc <= fetch_pc;
              state    <= DRAIN;
            end
          end else if (imem_ready) begin
            fetch_pc <= fetch_pc + 32'd4;
            if (accept) begin
              if_pc          <= fetch_pc;
              if_instruction <= imem_rdata;
              if_valid       <= 1'b1;
            end else begin
              skid_pc    <= fetch_pc;
              skid_instr <= imem_rdata;
              state      <= HOLD;
            end
          end else if (pipeline_en) begin
            if_valid       <= 1'b0;
            if_instruction <= NOP_INSTR;
          end
        end

        HOLD: begin
          if (redirect_valid) begin
            if_valid       <= 1'b0;
            if_instruction <= NOP_INSTR;
            fetch_pc       <= redirect_tgt;
            state          <= FETCH;
          end else if (pipeline_en) begin
            if_pc          <= skid_pc;
            if_instruction <= skid_instr;
            if_valid       <= 1'b1;
            state          <= FETCH;
          end
        end

        DRAIN: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_tgt;
          end
          if (imem_ready) begin
            state <= FETCH;
          end
        end

        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic, checked by a program-order scoreboard.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipeline_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] if_pc;
  logic [31:0] if_instruction;
  logic        if_valid;

  int checks = 0;
  int errors = 0;
  int consumed = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_next;
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic [31:0] exp_pc;

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst(rst), .pipeline_en(pipeline_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .if_pc(if_pc), .if_instruction(if_instruction), .if_valid(if_valid)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a distinct word per address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F96;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected program-order stream; restarted at every redirect or reset.
  task automatic topup();
    while (exp_q.size() < 16) begin
      exp_q.push_back(exp_next);
      exp_next = exp_next + 32'd4;
    end
  endtask

  task automatic flush(input logic [31:0] target);
    exp_q.delete();
    exp_next = target & 32'hFFFF_FFFC;
    topup();
  endtask

  task automatic step(input logic pe, input logic rdy, input logic rv, input logic [31:0] rpc);
    pipeline_en    = pe;
    imem_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_rdata     = rdy ? mem(imem_addr) : $urandom;
    @(posedge clk);
    #1;
    if (rv) flush(rpc);
    topup();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pipeline_en = 1'b1;
    imem_ready = 1'b1;
    redirect_valid = 1'b0;
    imem_rdata = mem(imem_addr);
    @(posedge clk);
    #1;
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instruction, NOP_INSTR);
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst_imem_addr", imem_addr, RESET_PC);
    rst = 1'b0;
    flush(RESET_PC);
    chk("boot_imem_req", {31'b0, imem_req}, 32'd0);
  endtask

  // Monitor: every instruction IF/ID consumes must be the next one in program order.
  always @(negedge clk) begin
    if (rst) begin
      prev_wait = 1'b0;
    end else begin
      if (prev_wait) begin
        chk("addr_req_held", {31'b0, imem_req}, 32'd1);
        chk("addr_stable", imem_addr, prev_addr);
      end
      if (if_valid && pipeline_en) begin
        consumed++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: got pc %h expected none at %0t", if_pc, $time);
        end else begin
          exp_pc = exp_q.pop_front();
          chk("sb_pc", if_pc, exp_pc);
          chk("sb_instr", if_instruction, mem(exp_pc));
        end
      end
      if (!if_valid) chk("nop_when_invalid", if_instruction, NOP_INSTR);
      prev_wait = imem_req && !imem_ready;
      prev_addr = imem_addr;
    end
  end

  initial begin
    int start_cnt;
    logic        pe, rdy, rv;
    logic [31:0] rpc;

    @(posedge clk);
    #1;
    do_reset();

    // Zero-wait streaming from reset.
    step(1, 1, 0, 0);
    chk("boot_to_fetch_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    step(1, 1, 0, 0);
    chk("stream_addr4", imem_addr, 32'h4);
    chk("stream_pc0", if_pc, 32'h0);
    chk("stream_valid0", {31'b0, if_valid}, 32'd1);
    step(1, 1, 0, 0);
    chk("stream_addr8", imem_addr, 32'h8);
    chk("stream_pc4", if_pc, 32'h4);
    step(1, 1, 0, 0);
    chk("stream_pc8", if_pc, 32'h8);
    step(1, 1, 0, 0);
    chk("pre_wait_addr", imem_addr, 32'h10);

    // Three wait states at 0x10.
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0);
      chk("wait_addr", imem_addr, 32'h10);
      chk("wait_invalid", {31'b0, if_valid}, 32'd0);
    end
    step(1, 1, 0, 0);
    chk("after_wait_pc", if_pc, 32'h10);
    chk("after_wait_valid", {31'b0, if_valid}, 32'd1);

    // Stall with 0x20 on the output while 0x24 returns.
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
    chk("hold_setup_pc", if_pc, 32'h20);
    step(0, 1, 0, 0);
    chk("hold_req_low", {31'b0, imem_req}, 32'd0);
    chk("hold_pc_kept", if_pc, 32'h20);
    step(0, 0, 0, 0);
    chk("hold_valid_kept", {31'b0, if_valid}, 32'd1);
    step(1, 0, 0, 0);
    chk("skid_pc_out", if_pc, 32'h24);
    chk("resume_addr", imem_addr, 32'h28);

    // Redirect to an unaligned target over a waited fetch at 0x30.
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("pre_drain_addr", imem_addr, 32'h30);
    step(1, 0, 1, 32'h103);
    chk("drain_addr", imem_addr, 32'h30);
    chk("drain_invalid", {31'b0, if_valid}, 32'd0);
    step(1, 0, 0, 0);
    chk("drain_addr_held", imem_addr, 32'h30);
    step(1, 1, 0, 0);
    chk("drain_discard", {31'b0, if_valid}, 32'd0);
    chk("post_drain_addr", imem_addr, 32'h100);
    step(1, 1, 0, 0);
    chk("redirect_pc_out", if_pc, 32'h100);

    // Redirect while parked in the skid.
    step(0, 1, 0, 0);
    chk("hold2_req_low", {31'b0, imem_req}, 32'd0);
    step(0, 1, 1, 32'h200);
    chk("hold_redirect_invalid", {31'b0, if_valid}, 32'd0);
    chk("hold_redirect_addr", imem_addr, 32'h200);
    step(1, 1, 0, 0);
    chk("hold_redirect_pc", if_pc, 32'h200);

    // Address wrap at the top of the space.
    step(1, 1, 1, 32'hFFFF_FFFC);
    chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    step(1, 1, 0, 0);
    chk("wrap_pc_top", if_pc, 32'hFFFF_FFFC);
    chk("wrap_addr_zero", imem_addr, 32'h0);
    step(1, 1, 0, 0);
    chk("wrap_pc_zero", if_pc, 32'h0);

    // Reset in the middle of a waited access.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    do_reset();
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("post_reset_pc", if_pc, RESET_PC);
    chk("post_reset_valid", {31'b0, if_valid}, 32'd1);

    // Random traffic against the program-order scoreboard.
    start_cnt = consumed;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        pe  = ($urandom_range(0, 3) != 0);
        rdy = imem_req ? ($urandom_range(0, 2) != 0) : 1'b0;
        rv  = ($urandom_range(0, 19) == 0);
        rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
        step(pe, rdy, rv, rpc);
      end
    end
    chk("random_progress", {31'b0, (consumed - start_cnt) > 300}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h00000013, instruction driven when no valid fetch is presented.
REQ-003 SHALL have port clk  in  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port pipeline_en  in  1  downstream advance; 1 = IF/ID consumes the current output this cycle.
REQ-006 SHALL have port redirect_valid  in  1  branch/jump taken from EX.
REQ-007 SHALL have port redirect_pc  in  32  redirect target.
REQ-008 SHALL have port imem_req  out  1  fetch request.
REQ-009 SHALL have port imem_addr  out  32  word-aligned fetch address.
REQ-010 SHALL have port imem_ready  in  1  imem_rdata valid for imem_addr this cycle.
REQ-011 SHALL have port imem_rdata  in  32  fetched instruction.
REQ-012 SHALL have ports if_pc  out  32, if_instruction  out  32, if_valid  out  1: registered fetch output to IF/ID.

Function
REQ-013 SHALL implement FSM states BOOT, FETCH, HOLD, DRAIN; registers fetch_pc, drain_pc, skid_pc, skid_instr.
REQ-014 SHALL drive imem_req=1 only in FETCH and DRAIN; imem_addr = fetch_pc in FETCH, drain_pc in DRAIN, fetch_pc otherwise.
REQ-015 SHALL keep imem_addr stable while imem_req=1 and imem_ready=0 (memory contract).
REQ-016 SHALL force bits [1:0] of every loaded PC (RESET_PC, redirect_pc) to 2'b00.
REQ-017 BOOT: imem_req=0; next state FETCH unconditionally (or FETCH at redirect_pc if redirect_valid).
REQ-018 FETCH, accept = !if_valid | pipeline_en; on imem_ready & accept: if_pc<=fetch_pc, if_instruction<=imem_rdata, if_valid<=1, fetch_pc<=fetch_pc+4 (mod 2^32), stay FETCH.
REQ-019 FETCH, imem_ready & !accept: skid_pc<=fetch_pc, skid_instr<=imem_rdata, fetch_pc<=fetch_pc+4, go HOLD; outputs unchanged.
REQ-020 FETCH, !imem_ready & pipeline_en: if_valid<=0, if_instruction<=NOP_INSTR, if_pc unchanged.
REQ-021 HOLD: on pipeline_en, output<=skid contents with if_valid=1, go FETCH; else hold all.
REQ-022 Redirect (highest priority, any state): if_valid<=0, if_instruction<=NOP_INSTR, skid discarded, any imem_rdata returned that cycle discarded.
REQ-023 Redirect in FETCH with imem_ready=1, or in BOOT/HOLD: fetch_pc<=redirect_pc, state FETCH.
REQ-024 Redirect in FETCH with imem_ready=0: drain_pc<=fetch_pc, fetch_pc<=redirect_pc, go DRAIN.
REQ-025 DRAIN: imem_req=1 at drain_pc; on imem_ready data discarded, go FETCH; new redirect in DRAIN updates fetch_pc only.
REQ-026 Fetch latency: instruction at address A appears on if_* the cycle after imem_ready for A; zero-wait memory sustains 1 instr/cycle.
REQ-027 Instructions SHALL reach if_* in program order with no duplication or loss while no redirect occurs.

Reset
REQ-028 On rst: state BOOT, fetch_pc=RESET_PC, drain_pc=skid_pc=0, skid_instr=NOP_INSTR, if_pc=0, if_instruction=NOP_INSTR, if_valid=0, imem_req=0.
REQ-029 Reset mid-wait or mid-DRAIN SHALL abandon the access; no stale data reaches if_* after deassertion.

Verification
REQ-030 Reset release, zero-wait memory, pipeline_en=1 -> imem_addr 0,4,8 on consecutive cycles; if_pc 0,4,8 one cycle later, if_valid=1.
REQ-031 imem_ready low 3 cycles at addr 0x10 -> imem_addr held 0x10, if_valid=0/NOP during wait, then if_pc=0x10.
REQ-032 pipeline_en=0 while if_pc=0x20 valid and 0x24 returns -> HOLD, imem_req=0; pipeline_en=1 -> if_pc=0x24, fetch resumes at 0x28.
REQ-033 redirect_pc=0x103 during waited fetch at 0x30 -> DRAIN holds addr 0x30, data discarded, next fetch 0x100, if_pc=0x100.
REQ-034 redirect in same cycle as imem_ready and pipeline_en=0 in HOLD -> if_valid=0, skid dropped, next imem_addr=redirect target.
REQ-035 fetch_pc=0xFFFFFFFC accepted -> next imem_addr=0x00000000.
